// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared ASCII command codes, rx FSM states and tick divisor helper
package uart_pkg;

  localparam logic [7:0] CMD_CLR     = 8'h30;
  localparam logic [7:0] CMD_ALL_U   = 8'h41;
  localparam logic [7:0] CMD_ALL_L   = 8'h61;
  localparam logic [7:0] CMD_BLINK_U = 8'h42;
  localparam logic [7:0] CMD_BLINK_L = 8'h62;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int calc_div(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling 8N1 receiver with start-glitch rejection and framing check
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int OS_W  = $clog2(OVERSAMPLE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

  rx_state_t        r_state, w_state_next;
  logic [1:0]       r_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_armed;
  logic             r_valid;
  logic             r_frame_err;
  logic             w_rx_s;
  logic             w_tick;
  logic             w_sample;

  assign w_rx_s      = r_sync[1];
  assign w_tick      = (r_state != IDLE) && (r_div_cnt == DIV_LAST);
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;

  always_comb begin
    w_sample     = 1'b0;
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_armed && !w_rx_s) w_state_next = START;
      end
      START: begin
        w_sample = w_tick && (r_os_cnt == OS_HALF);
        if (w_sample) w_state_next = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        w_sample = w_tick && (r_os_cnt == OS_LAST);
        if (w_sample && (r_bit_idx == 3'd7)) w_state_next = STOP;
      end
      STOP: begin
        w_sample = w_tick && (r_os_cnt == OS_LAST);
        if (w_sample) w_state_next = w_rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (w_rx_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync      <= 2'b11;
      r_div_cnt   <= '0;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_armed     <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_armed     <= r_armed | w_rx_s;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      // Counters sit at zero in IDLE so they start fresh from the detected falling edge
      if (r_state == IDLE) begin
        r_div_cnt <= '0;
        r_os_cnt  <= '0;
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_os_cnt  <= w_sample ? '0 : r_os_cnt + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (w_sample) begin
        case (r_state)
          START: r_bit_idx <= '0;
          DATA: begin
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
          STOP: begin
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_led_ctrl.sv
// rtl/uart_cmd_led_ctrl.sv - ASCII command decoder driving NUM_LEDS channels with global blink
module uart_cmd_led_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int NUM_LEDS    = 3,
  parameter int BLINK_HZ    = 2
) (
  input  logic                clk_12mhz,
  input  logic                rst,
  input  logic                uart_rx_pin,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                cmd_err,
  output logic                blink_en
);

  localparam int BLINK_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int BW        = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [NUM_LEDS-1:0] r_led_state;
  logic [NUM_LEDS-1:0] w_led_next;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_blink_phase;
  logic                w_blink_next;
  logic                w_phase_next;
  logic                w_blink_rise;
  logic                w_blink_wrap;
  logic                w_cmd_err;
  logic [7:0]          w_digit;

  uart_rx_os #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx (
    .i_clk      (clk_12mhz),
    .i_rst      (rst),
    .i_rx       (uart_rx_pin),
    .o_data     (rx_data),
    .o_valid    (rx_valid),
    .o_frame_err(frame_err)
  );

  assign w_digit = rx_data - CMD_CLR;

  always_comb begin
    w_led_next   = r_led_state;
    w_blink_next = blink_en;
    w_cmd_err    = 1'b0;
    if (rx_valid) begin
      if ((rx_data >= 8'h31) && (rx_data <= 8'h39)) begin
        if (w_digit > 8'(NUM_LEDS)) begin
          w_cmd_err = 1'b1;
        end else begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_digit == 8'(i + 1)) w_led_next[i] = ~r_led_state[i];
          end
        end
      end else begin
        case (rx_data)
          CMD_CLR: begin
            w_led_next   = '0;
            w_blink_next = 1'b0;
          end
          CMD_ALL_U, CMD_ALL_L:     w_led_next   = '1;
          CMD_BLINK_U, CMD_BLINK_L: w_blink_next = ~blink_en;
          ASCII_CR, ASCII_LF:       ;
          default:                  w_cmd_err    = 1'b1;
        endcase
      end
    end
  end

  // Enabling blink restarts the phase dark so the first visible period is a full one
  assign w_blink_rise = w_blink_next & ~blink_en;
  assign w_blink_wrap = (r_blink_cnt == BLINK_LAST);
  assign w_phase_next = w_blink_rise ? 1'b0 : (w_blink_wrap ? ~r_blink_phase : r_blink_phase);

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      r_led_state   <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      blink_en      <= 1'b0;
      cmd_err       <= 1'b0;
      led_out       <= '0;
    end else begin
      r_led_state   <= w_led_next;
      blink_en      <= w_blink_next;
      cmd_err       <= w_cmd_err;
      r_blink_phase <= w_phase_next;
      r_blink_cnt   <= (w_blink_rise || w_blink_wrap) ? '0 : r_blink_cnt + 1'b1;
      led_out       <= w_led_next & {NUM_LEDS{~w_blink_next | w_phase_next}};
    end
  end

endmodule

// File: tb/tb_uart_cmd_led_ctrl.sv
// tb/tb_uart_cmd_led_ctrl.sv - scoreboard bench for uart_cmd_led_ctrl with a behavioural LED model
module tb_uart_cmd_led_ctrl;

  localparam int CLK_HZ    = 12000000;
  localparam int BAUD      = 75000;
  localparam int OS        = 16;
  localparam int NLED      = 3;
  localparam int BLINK_HZ  = 6000;
  localparam int BIT_CLK   = CLK_HZ / BAUD;
  localparam int BLINK_PER = CLK_HZ / (2 * BLINK_HZ);

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx  = 1'b1;
  logic [NLED-1:0] led_out;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            frame_err;
  logic            cmd_err;
  logic            blink_en;

  uart_cmd_led_ctrl #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .NUM_LEDS   (NLED),
    .BLINK_HZ   (BLINK_HZ)
  ) dut (
    .clk_12mhz  (clk),
    .rst        (rst),
    .uart_rx_pin(rx),
    .led_out    (led_out),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .cmd_err    (cmd_err),
    .blink_en   (blink_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  logic [NLED-1:0] m_led = '0;
  bit              m_blink = 1'b0;
  int              m_t0 = 0;
  logic [7:0]      m_last = '0;
  bit              m_err_pend = 1'b0;
  int              rst_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic bit model_decode(input logic [7:0] b);
    int d;
    d = int'(b) - 48;
    if (d >= 1 && d <= 9) begin
      if (d > NLED) return 1'b1;
      m_led[d-1] = ~m_led[d-1];
    end else if (b == "0") begin
      m_led   = '0;
      m_blink = 1'b0;
    end else if (b == "a" || b == "A") begin
      m_led = '1;
    end else if (b == "b" || b == "B") begin
      m_blink = !m_blink;
      if (m_blink) m_t0 = cyc + 1;
    end else if (b != 8'h0D && b != 8'h0A) begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NLED-1:0] exp_led();
    if (!m_blink) return m_led;
    return ((((cyc - m_t0) / BLINK_PER) % 2) == 1) ? m_led : '0;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rst_cnt++;
        if (rst_cnt == 2)
          check("reset_outputs", 32'({led_out, rx_data, rx_valid, frame_err, cmd_err, blink_en}), 32'd0);
        m_led      = '0;
        m_blink    = 1'b0;
        m_last     = '0;
        m_err_pend = 1'b0;
        exp_q.delete();
      end else begin
        rst_cnt = 0;
        check("led_out", 32'(led_out), 32'(exp_led()));
        check("blink_en", 32'(blink_en), 32'(m_blink));
        check("cmd_err", 32'(cmd_err), 32'(m_err_pend));
        m_err_pend = 1'b0;
        if (rx_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({rx_valid, frame_err}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'({rx_valid, frame_err}), e.is_ferr ? 32'd1 : 32'd2);
            if (!e.is_ferr) begin
              check("rx_data_new", 32'(rx_data), 32'(e.data));
              m_last     = e.data;
              m_err_pend = model_decode(e.data);
            end
          end
        end else begin
          check("rx_data_hold", 32'(rx_data), 32'(m_last));
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int bc, input logic stop_lvl, input int stop_bits);
    rx = 1'b0;
    wait_clks(bc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bc);
    end
    rx = stop_lvl;
    wait_clks(bc * stop_bits);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bc);
    exp_q.push_back('{is_ferr: 1'b0, data: b});
    send_bits(b, bc, 1'b1, 1);
  endtask

  logic [7:0] pool [13];
  logic [7:0] rb;
  logic [7:0] partial;
  int         bc;

  initial begin : stim
    pool = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h39, 8'h61, 8'h41,
             8'h62, 8'h42, 8'h0D, 8'h0A, 8'h00};
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2 * BIT_CLK);

    send_byte("1", BIT_CLK);
    send_byte("2", BIT_CLK);
    send_byte("3", BIT_CLK);
    wait_clks(BIT_CLK);
    send_byte("0", BIT_CLK);
    send_byte("2", BIT_CLK);
    send_byte("2", BIT_CLK);
    send_byte("5", BIT_CLK);
    wait_clks(BIT_CLK);

    rx = 1'b0;
    wait_clks(40);
    rx = 1'b1;
    wait_clks(2 * BIT_CLK);
    send_byte("1", BIT_CLK);

    exp_q.push_back('{is_ferr: 1'b1, data: 8'h31});
    send_bits(8'h31, BIT_CLK, 1'b0, 3);
    wait_clks(BIT_CLK);
    send_byte("1", BIT_CLK);

    send_byte("a", BIT_CLK);
    send_byte("b", BIT_CLK);
    wait_clks(4 * BLINK_PER + 500);
    send_byte("b", BIT_CLK);
    wait_clks(2 * BIT_CLK);

    partial = "1";
    rx = 1'b0;
    wait_clks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      wait_clks(BIT_CLK);
    end
    rx = partial[4];
    wait_clks(BIT_CLK / 2);
    rst = 1'b1;
    wait_clks(BIT_CLK - BIT_CLK / 2);
    for (int i = 5; i < 8; i++) begin
      rx = partial[i];
      wait_clks(BIT_CLK);
    end
    rx = 1'b1;
    wait_clks(BIT_CLK);
    rst = 1'b0;
    wait_clks(2 * BIT_CLK);
    send_byte("1", BIT_CLK);

    for (int n = 0; n < 8; n++) begin
      pool[12] = 8'($urandom_range(0, 255));
      rb = pool[$urandom_range(0, 12)];
      bc = BIT_CLK - 3 + int'($urandom_range(0, 6));
      send_byte(rb, bc);
      if ($urandom_range(0, 2) != 0) wait_clks(int'($urandom_range(1, 2)) * BIT_CLK);
    end

    wait_clks(3 * BIT_CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_led_ctrl.md
Name: uart_cmd_led_ctrl

Overview:
Parametrised successor to the fixed 3-LED UART control path. Receives 8N1 serial at BAUD using an OVERSAMPLE× receiver with start-bit glitch rejection and framing-error detection. Decodes ASCII commands into NUM_LEDS independent LED channels, with a global blink mode. Sits between uart_rx_pin and the ext_led outputs inside top.

Parameters:
CLK_FREQ_HZ, 12000000, system clock frequency
BAUD, 9600, serial bit rate
OVERSAMPLE, 16, sample ticks per bit (even, ≥8)
NUM_LEDS, 3, LED channel count (1..9)
BLINK_HZ, 2, blink toggle rate

Ports:
clk_12mhz  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
uart_rx_pin  in  1  asynchronous serial input, idle high
led_out  out  NUM_LEDS  LED drive, bit i = channel i+1
rx_data  out  8  last good byte received
rx_valid  out  1  1-cycle pulse when rx_data updates
frame_err  out  1  1-cycle pulse on a bad stop bit
cmd_err  out  1  1-cycle pulse on an unrecognised/out-of-range byte
blink_en  out  1  current blink-mode state

Behaviour:
- Reset (rst=1 at a clk_12mhz edge): all outputs 0, FSM IDLE, counters 0, synchroniser stages 1, armed=0. Reset mid-frame discards the partial byte.
- rx passes through a 2-FF synchroniser (reset value 1). All logic uses the synchronised rx_s.
- Tick divisor DIV = CLK_FREQ_HZ/(BAUD*OVERSAMPLE), integer-truncated (78 at defaults). Tick counter runs only outside IDLE and reloads to 0 on start detection.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a start is detected only when armed=1 and rx_s=0. armed is set once rx_s=1 has been seen. On detect, go to START.
  - START: at OVERSAMPLE/2 ticks, sample rx_s. If 1 (glitch), return to IDLE with no pulse. If 0, go to DATA with bit index 0.
  - DATA: every OVERSAMPLE ticks, sample rx_s into the shift register LSB-first. After bit 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: latch rx_data, pulse rx_valid, go to IDLE.
    - If 0: pulse frame_err, leave rx_data unchanged, decode nothing, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1 (break handling), then go to IDLE.
- Decoder acts in the cycle after rx_valid, so LED latency is 1 clk after the rx_valid pulse.
  - '1'..'9' with value d ≤ NUM_LEDS: toggle led_state[d-1].
  - '1'..'9' with d > NUM_LEDS: pulse cmd_err, no state change.
  - '0': clear all led_state bits and set blink_en=0.
  - 'a'/'A': set all led_state bits.
  - 'b'/'B': toggle blink_en.
  - CR and LF: ignored silently.
  - Any other byte: pulse cmd_err.
- Blink: a counter of period CLK_FREQ_HZ/(2*BLINK_HZ) toggles blink_phase. The counter and blink_phase reset to 0 whenever blink_en changes 0→1.
- led_out = led_state & {NUM_LEDS{~blink_en | blink_phase}}, registered. A command and a blink-phase toggle in the same cycle are both applied; they are independent registers.
- Throughput: back-to-back frames with a one-bit stop and no idle gap are accepted. Baud error tolerance is at least ±2%.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants: CMD_CLR='0', CMD_ALL_U/L='A'/'a', CMD_BLINK_U/L='B'/'b', ASCII_CR, ASCII_LF.
  - FSM state enum: rx_state_t.
  - Function calc_div(clk, baud, os).
- Sub-module uart_rx_os holds the synchroniser, tick generator and FSM, and outputs rx_data, rx_valid and frame_err.
- The top of uart_cmd_led_ctrl holds the decoder and blink logic.

Test Plan:
- Defaults. Send '1', '2', '3' at 1250 clk/bit → led_out=111, rx_valid 3 pulses, rx_data=0x33. Then send '0' → led_out=000.
- Send '2' twice → led_out[1] goes 0→1→0. Send '5' with NUM_LEDS=3 → cmd_err 1 pulse, led_out unchanged, rx_valid still pulses.
- Drive a 400-clk low glitch on rx → no rx_valid, no frame_err, FSM back in IDLE, next '1' decodes correctly.
- Send 0x31 with the stop bit held low for 3 bit-times → frame_err 1 pulse, led_out unchanged. A subsequent '1' is accepted only after the line returns high.
- Send 'a' then 'b' with BLINK_HZ overridden so the period is 1000 clk → led_out alternates 111/000 every 1000 clk starting at 000. Send 'b' → steady 111.
- Assert rst during data bit 4 of '1' → all outputs 0 next cycle. The remainder of that frame produces no rx_valid; the next full '1' gives led_out=001.
